// File: rtl/cart_mem_arbiter.sv
// Arbitrates the single cartridge memory port between slot A, slot B and the ROM loader.
// Loader has fixed priority in IDLE; A/B alternate on ties; a watchdog bounds every access.
module cart_mem_arbiter #(
    parameter int unsigned ADDR_W  = 25,
    parameter int unsigned TO_W    = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_din,
    output logic              a_ack,

    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_din,
    output logic              b_ack,

    input  logic              l_req,
    input  logic              l_wr,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [7:0]        l_din,
    output logic              l_ack,

    output logic [7:0]        rd_data,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic              mem_ack,
    input  logic [7:0]        mem_dout,

    output logic [1:0]        grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    localparam logic [1:0] GntNone = 2'd0;
    localparam logic [1:0] GntA    = 2'd1;
    localparam logic [1:0] GntB    = 2'd2;
    localparam logic [1:0] GntL    = 2'd3;

    localparam logic [TO_W-1:0] TimeoutVal = TO_W'(TIMEOUT);

    state_e              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_din_q, mem_din_d;
    logic [7:0]          rd_data_q, rd_data_d;
    logic                timeout_err_q, timeout_err_d;
    logic [TO_W-1:0]     wdog_q, wdog_d;
    logic                last_b_q, last_b_d;   // 1: slot B was served last

    logic [1:0]          pick;
    logic [TO_W-1:0]     wdog_inc;

    assign wdog_inc = wdog_q + TO_W'(1);

    // Owner selection, only acted upon in IDLE.
    always_comb begin
        pick = GntNone;
        if (l_req) begin
            pick = GntL;
        end else if (a_req && b_req) begin
            pick = last_b_q ? GntA : GntB;
        end else if (a_req) begin
            pick = GntA;
        end else if (b_req) begin
            pick = GntB;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        mem_req_d     = mem_req_q;
        mem_wr_d      = mem_wr_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        rd_data_d     = rd_data_q;
        timeout_err_d = timeout_err_q;
        wdog_d        = wdog_q;
        last_b_d      = last_b_q;

        unique case (state_q)
            StIdle: begin
                grant_d = GntNone;
                if (pick != GntNone) begin
                    grant_d   = pick;
                    mem_req_d = 1'b1;
                    wdog_d    = '0;
                    state_d   = StIssue;
                    case (pick)
                        GntL: begin
                            mem_wr_d   = l_wr;
                            mem_addr_d = l_addr;
                            mem_din_d  = l_din;
                        end
                        GntB: begin
                            mem_wr_d   = b_wr;
                            mem_addr_d = b_addr;
                            mem_din_d  = b_din;
                        end
                        default: begin
                            mem_wr_d   = a_wr;
                            mem_addr_d = a_addr;
                            mem_din_d  = a_din;
                        end
                    endcase
                end
            end
            StIssue: begin
                wdog_d = wdog_inc;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    rd_data_d = mem_wr_q ? 8'hFF : mem_dout;
                    state_d   = StDone;
                end else if (wdog_inc == TimeoutVal) begin
                    mem_req_d     = 1'b0;
                    rd_data_d     = 8'hFF;
                    timeout_err_d = 1'b1;
                    state_d       = StDone;
                end
            end
            StDone: begin
                wdog_d  = '0;
                grant_d = GntNone;
                state_d = StIdle;
                if (grant_q == GntA) begin
                    last_b_d = 1'b0;
                end else if (grant_q == GntB) begin
                    last_b_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            grant_q       <= GntNone;
            mem_req_q     <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            rd_data_q     <= '0;
            timeout_err_q <= 1'b0;
            wdog_q        <= '0;
            last_b_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            mem_req_q     <= mem_req_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            rd_data_q     <= rd_data_d;
            timeout_err_q <= timeout_err_d;
            wdog_q        <= wdog_d;
            last_b_q      <= last_b_d;
        end
    end

    assign a_ack       = (state_q == StDone) && (grant_q == GntA);
    assign b_ack       = (state_q == StDone) && (grant_q == GntB);
    assign l_ack       = (state_q == StDone) && (grant_q == GntL);
    assign rd_data     = rd_data_q;
    assign mem_req     = mem_req_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

endmodule
